ddr5_cmd_sequencer: RTL and testbench

Synthesizable single-channel DDR5 command sequencer for the memory-controller datapath. It sits between the CPU-side request stream and the DIMM command bus. It buffers requests in a FIFO, decodes each 34-bit address into bank group/bank/row/column, and issues the two-cycle ACT, RD/WR and PRE command sequence under a closed-page policy, enforcing tRCD, tCAS/tCWD, tBURST, tWR, tRAS and tRP.

---
 rtl/ddr5_cmd_sequencer_if.sv | 29 ++
 rtl/ddr5_cmd_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_ddr5_cmd_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr5_cmd_sequencer_if.sv
// Request / DIMM-command bundle between the CPU-side requester and the DDR5 command sequencer.
interface ddr5_cmd_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [33:0] req_addr;
  logic        drop_err;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        cmp_valid;
  logic        cmp_write;
  logic        busy;

  modport master (
    output req_valid, req_write, req_addr,
    input  req_ready, drop_err, cmd_valid, cmd_type, cmd_bg, cmd_bank,
           cmd_row, cmd_col, cmp_valid, cmp_write, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    output req_ready, drop_err, cmd_valid, cmd_type, cmd_bg, cmd_bank,
           cmd_row, cmd_col, cmp_valid, cmp_write, busy
  );
endinterface

// File: rtl/ddr5_cmd_sequencer.sv
// Single-channel DDR5 closed-page command sequencer: request FIFO, address decode,
// and ACT/RD|WR/PRE issue with tRCD, latency, burst, tWR, tRAS and tRP spacing.
module ddr5_cmd_sequencer #(
  parameter int DEPTH   = 16,
  parameter int T_RCD   = 39,
  parameter int T_CAS   = 40,
  parameter int T_CWD   = 38,
  parameter int T_BURST = 8,
  parameter int T_WR    = 30,
  parameter int T_RAS   = 76,
  parameter int T_RP    = 39
) (
  input logic             clk,
  input logic             rst,
  ddr5_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PRE_RD = (T_RCD + T_CAS + T_BURST > T_RAS) ? T_RCD + T_CAS + T_BURST : T_RAS;
  localparam int PRE_WR = (T_RCD + T_CWD + T_BURST + T_WR > T_RAS) ?
                          T_RCD + T_CWD + T_BURST + T_WR : T_RAS;
  // cnt holds the bus-cycle offset of the output being driven, so each wait state
  // hands over one cycle early to let the next command register land on time.
  localparam logic [15:0] RCD_M2    = 16'(T_RCD - 2);
  localparam logic [15:0] PRE_RD_M2 = 16'(PRE_RD - 2);
  localparam logic [15:0] PRE_WR_M2 = 16'(PRE_WR - 2);
  localparam logic [15:0] RP_M3     = 16'(T_RP - 3);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  localparam logic [2:0] C_ACT0 = 3'd0, C_ACT1 = 3'd1, C_RD0 = 3'd2, C_RD1 = 3'd3,
                         C_WR0 = 3'd4, C_WR1 = 3'd5, C_PRE = 3'd6;

  typedef struct packed {
    logic        write;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic [15:0] row;
    logic [9:0]  col;
  } req_t;

  typedef enum logic [3:0] {
    IDLE, ACT0, ACT1, WAIT_RCD, CMD0, CMD1, WAIT_PRE, PRE, WAIT_RP
  } state_t;

  req_t            mem [DEPTH];
  req_t            in_req, cur;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            accept, push, pop;
  state_t          state;
  logic [15:0]     cnt, cnt_inc;
  logic            unused_addr;

  assign unused_addr = ^bus.req_addr[1:0];
  assign accept  = bus.req_valid & bus.req_ready;
  assign push    = accept & ~bus.req_addr[6];
  assign pop     = (state == IDLE) && (count != '0);
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign in_req  = '{write: bus.req_write, bg: bus.req_addr[9:7], bank: bus.req_addr[11:10],
                     row: bus.req_addr[33:18], col: {bus.req_addr[17:12], bus.req_addr[5:2]}};

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bus.req_ready <= 1'b1;
      bus.drop_err  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count         <= count_nxt;
      bus.req_ready <= (count_nxt < FULL);
      bus.drop_err  <= accept & bus.req_addr[6];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      cur           <= '0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_type  <= '0;
      bus.cmd_bg    <= '0;
      bus.cmd_bank  <= '0;
      bus.cmd_row   <= '0;
      bus.cmd_col   <= '0;
      bus.cmp_valid <= 1'b0;
      bus.cmp_write <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.cmd_valid <= 1'b0;
      bus.cmd_type  <= '0;
      bus.cmd_bg    <= '0;
      bus.cmd_bank  <= '0;
      bus.cmd_row   <= '0;
      bus.cmd_col   <= '0;
      bus.cmp_valid <= 1'b0;
      bus.cmp_write <= 1'b0;
      bus.busy      <= 1'b1;
      cnt           <= cnt_inc;
      case (state)
        IDLE: begin
          bus.busy <= pop || (count_nxt != '0);
          if (pop) begin
            cur   <= mem[rd_ptr];
            state <= ACT0;
          end
        end
        ACT0: begin
          bus.cmd_valid <= 1'b1;
          bus.cmd_type  <= C_ACT0;
          bus.cmd_bg    <= cur.bg;
          bus.cmd_bank  <= cur.bank;
          bus.cmd_row   <= cur.row;
          cnt           <= '0;
          state         <= ACT1;
        end
        ACT1: begin
          bus.cmd_valid <= 1'b1;
          bus.cmd_type  <= C_ACT1;
          bus.cmd_bg    <= cur.bg;
          bus.cmd_bank  <= cur.bank;
          bus.cmd_row   <= cur.row;
          state         <= (T_RCD <= 2) ? CMD0 : WAIT_RCD;
        end
        WAIT_RCD: if (cnt >= RCD_M2) state <= CMD0;
        CMD0: begin
          bus.cmd_valid <= 1'b1;
          bus.cmd_type  <= cur.write ? C_WR0 : C_RD0;
          bus.cmd_bg    <= cur.bg;
          bus.cmd_bank  <= cur.bank;
          bus.cmd_col   <= cur.col;
          state         <= CMD1;
        end
        CMD1: begin
          bus.cmd_valid <= 1'b1;
          bus.cmd_type  <= cur.write ? C_WR1 : C_RD1;
          bus.cmd_bg    <= cur.bg;
          bus.cmd_bank  <= cur.bank;
          bus.cmd_col   <= cur.col;
          state         <= WAIT_PRE;
        end
        WAIT_PRE: if (cnt >= (cur.write ? PRE_WR_M2 : PRE_RD_M2)) state <= PRE;
        PRE: begin
          bus.cmd_valid <= 1'b1;
          bus.cmd_type  <= C_PRE;
          bus.cmd_bg    <= cur.bg;
          bus.cmd_bank  <= cur.bank;
          bus.cmp_valid <= 1'b1;
          bus.cmp_write <= cur.write;
          cnt           <= '0;
          state         <= WAIT_RP;
        end
        WAIT_RP: begin
          // IDLE pop plus ACT0 register take two more cycles before ACT0 is on the bus
          if (cnt >= RP_M3) begin
            bus.busy <= (count_nxt != '0);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Directed bench for ddr5_cmd_sequencer: default-timing instance plus a T_RAS=120 instance.
module tb_ddr5_cmd_sequencer;
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  ddr5_cmd_sequencer_if if0();
  ddr5_cmd_sequencer_if if1();

  ddr5_cmd_sequencer u_dut (.clk(clk), .rst(rst0), .bus(if0));
  ddr5_cmd_sequencer #(.T_RAS(120)) u_ras (.clk(clk), .rst(rst1), .bus(if1));

  typedef struct {
    int cyc; int typ; int bg; int bank; int row; int col; bit cw; bit cmp;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  cyc = 0;
  int  nvec = 0;
  int  nerr = 0;
  bit  watch_busy = 0, watch_idle = 0;
  int  busy_low = 0, busy_high = 0;

  localparam logic [33:0] A = 34'h0_0004_0A84;

  always @(posedge clk) cyc <= cyc + 1;

  // cyc seen at a negedge is the index of the edge that launched the visible outputs
  always @(negedge clk) begin
    if (if0.cmd_valid || if0.cmp_valid)
      q0.push_back('{cyc, int'(if0.cmd_type), int'(if0.cmd_bg), int'(if0.cmd_bank),
                     int'(if0.cmd_row), int'(if0.cmd_col), if0.cmp_write, if0.cmp_valid});
    if (if1.cmd_valid || if1.cmp_valid)
      q1.push_back('{cyc, int'(if1.cmd_type), int'(if1.cmd_bg), int'(if1.cmd_bank),
                     int'(if1.cmd_row), int'(if1.cmd_col), if1.cmp_write, if1.cmp_valid});
    if (watch_busy && !if0.busy) busy_low++;
    if (watch_idle && if0.busy) busy_high++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] mk_addr(logic [15:0] row, logic [2:0] bg, logic [1:0] bank,
                                          logic [9:0] col);
    return {row, col[9:4], bank, bg, 1'b0, col[3:0], 2'b00};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds valid until accepted; e = index of the accepting edge. Leaves valid asserted.
  task automatic send(input int sel, input bit w, input logic [33:0] a, output int e);
    int  n = 0;
    bit  done = 0;
    if (sel == 0) begin if0.req_valid = 1; if0.req_write = w; if0.req_addr = a; end
    else          begin if1.req_valid = 1; if1.req_write = w; if1.req_addr = a; end
    e = -1;
    while (!done && n < 400) begin
      @(negedge clk);
      if ((sel == 0) ? if0.req_ready : if1.req_ready) begin
        e = cyc + 1;
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic release_req(input int sel);
    if (sel == 0) if0.req_valid = 0;
    else          if1.req_valid = 0;
  endtask

  task automatic wait_ev(input int sel, input int n, input int budget);
    int k = 0;
    while (((sel == 0) ? q0.size() : q1.size()) < n && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) check("wait_ev", (sel == 0) ? q0.size() : q1.size(), n);
  endtask

  task automatic chk_seq(input string tag, input int b, input int t, input bit w, input int bg,
                         input int bank, input int row, input int col, input int pre_at);
    check({tag, ".act0_cyc"}, q0[b].cyc, t);
    check({tag, ".act0_typ"}, q0[b].typ, 0);
    check({tag, ".act0_bg"}, q0[b].bg, bg);
    check({tag, ".act0_bank"}, q0[b].bank, bank);
    check({tag, ".act0_row"}, q0[b].row, row);
    check({tag, ".act1_cyc"}, q0[b+1].cyc, t + 1);
    check({tag, ".act1_typ"}, q0[b+1].typ, 1);
    check({tag, ".act1_row"}, q0[b+1].row, row);
    check({tag, ".cmd0_cyc"}, q0[b+2].cyc, t + 39);
    check({tag, ".cmd0_typ"}, q0[b+2].typ, w ? 4 : 2);
    check({tag, ".cmd0_col"}, q0[b+2].col, col);
    check({tag, ".cmd0_row"}, q0[b+2].row, 0);
    check({tag, ".cmd1_cyc"}, q0[b+3].cyc, t + 40);
    check({tag, ".cmd1_typ"}, q0[b+3].typ, w ? 5 : 3);
    check({tag, ".pre_cyc"}, q0[b+4].cyc, t + pre_at);
    check({tag, ".pre_typ"}, q0[b+4].typ, 6);
    check({tag, ".pre_bg"}, q0[b+4].bg, bg);
    check({tag, ".pre_bank"}, q0[b+4].bank, bank);
    check({tag, ".pre_col"}, q0[b+4].col, 0);
    check({tag, ".cmp_valid"}, q0[b+4].cmp, 1);
    check({tag, ".cmp_write"}, q0[b+4].cw, w);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int e, e2, t2, n1, k;
    int ea[20];
    logic [33:0] a1, a2;
    rst0 = 1; rst1 = 1;
    if0.req_valid = 0; if0.req_write = 0; if0.req_addr = '0;
    if1.req_valid = 0; if1.req_write = 0; if1.req_addr = '0;
    tick(3);
    check("rst.cmd_valid", if0.cmd_valid, 0);
    check("rst.cmd_type", if0.cmd_type, 0);
    check("rst.cmd_bg", if0.cmd_bg, 0);
    check("rst.cmd_bank", if0.cmd_bank, 0);
    check("rst.cmd_row", if0.cmd_row, 0);
    check("rst.cmd_col", if0.cmd_col, 0);
    check("rst.cmp_valid", if0.cmp_valid, 0);
    check("rst.cmp_write", if0.cmp_write, 0);
    check("rst.drop_err", if0.drop_err, 0);
    check("rst.busy", if0.busy, 0);
    check("rst.req_ready", if0.req_ready, 1);
    rst0 = 0; rst1 = 0;
    tick(1);

    // single read
    send(0, 0, A, e); release_req(0);
    wait_ev(0, 5, 200);
    chk_seq("rd", 0, e + 2, 0, 5, 2, 1, 1, 87);
    tick(50);
    check("rd.events", q0.size(), 5);
    check("rd.busy_after", if0.busy, 0);
    q0.delete();

    // single write
    send(0, 1, A, e); release_req(0);
    wait_ev(0, 5, 250);
    chk_seq("wr", 0, e + 2, 1, 5, 2, 1, 1, 115);
    tick(60);
    check("wr.events", q0.size(), 5);
    q0.delete();

    // back-to-back reads
    a1 = mk_addr(16'h1234, 3'd3, 2'd1, 10'h2A5);
    a2 = mk_addr(16'hBEEF, 3'd7, 2'd3, 10'h3FF);
    send(0, 0, a1, e);
    busy_low = 0; watch_busy = 1;
    send(0, 0, a2, e2); release_req(0);
    wait_ev(0, 10, 400);
    watch_busy = 0;
    check("b2b.busy_low", busy_low, 0);
    chk_seq("b2b0", 0, e + 2, 0, 3, 1, 16'h1234, 10'h2A5, 87);
    chk_seq("b2b1", 5, e + 2 + 126, 0, 7, 3, 16'hBEEF, 10'h3FF, 87);
    tick(60);
    q0.delete();

    // overrun: 20 back-to-back offers
    for (int i = 0; i < 20; i++) begin
      send(0, 0, mk_addr(16'(16'h100 + i), 3'(i % 8), 2'(i % 4), 10'(i)), ea[i]);
      if (i == 16) begin
        @(negedge clk);
        check("ovr.ready_low", if0.req_ready, 0);
        tick(1);
      end
    end
    release_req(0);
    for (int i = 1; i < 17; i++) check("ovr.accept_burst", ea[i], ea[0] + i);
    check("ovr.accept17", ea[17], ea[0] + 128);
    check("ovr.accept18", ea[18], ea[0] + 254);
    check("ovr.accept19", ea[19], ea[0] + 380);
    wait_ev(0, 100, 3000);
    for (int i = 0; i < 20; i++) begin
      check("ovr.act0_cyc", q0[5*i].cyc, ea[0] + 2 + 126 * i);
      check("ovr.act0_row", q0[5*i].row, 16'h100 + i);
      check("ovr.pre_bg", q0[5*i+4].bg, i % 8);
      check("ovr.pre_bank", q0[5*i+4].bank, i % 4);
      check("ovr.pre_cmp", q0[5*i+4].cmp, 1);
    end
    tick(60);
    q0.delete();

    // channel filter
    busy_high = 0; watch_idle = 1;
    send(0, 0, A | 34'h40, e); release_req(0);
    @(negedge clk);
    check("flt.drop_pulse", if0.drop_err, 1);
    tick(1);
    @(negedge clk);
    check("flt.drop_clear", if0.drop_err, 0);
    tick(20);
    watch_idle = 0;
    check("flt.busy", busy_high, 0);
    check("flt.no_cmd", q0.size(), 0);

    // T_RAS override, then reset mid-sequence
    send(1, 0, A, e); release_req(1);
    wait_ev(1, 5, 300);
    check("ras.act0_cyc", q1[0].cyc, e + 2);
    check("ras.rd0_cyc", q1[2].cyc, e + 2 + 39);
    check("ras.pre_cyc", q1[4].cyc, e + 2 + 120);
    check("ras.pre_typ", q1[4].typ, 6);
    send(1, 0, a1, e2); release_req(1);
    wait_ev(1, 6, 200);
    t2 = q1[5].cyc;
    check("ras.next_act0", t2, e + 2 + 159);
    k = 0;
    while (cyc < t2 + 60 && k < 500) begin @(negedge clk); k++; end
    check("ras.rst_point", cyc, t2 + 60);
    n1 = q1.size();
    check("ras.events_before_rst", n1, 9);
    rst1 = 1;
    #1;
    check("rst2.cmd_valid", if1.cmd_valid, 0);
    check("rst2.cmd_type", if1.cmd_type, 0);
    check("rst2.cmd_bg", if1.cmd_bg, 0);
    check("rst2.cmd_bank", if1.cmd_bank, 0);
    check("rst2.cmd_row", if1.cmd_row, 0);
    check("rst2.cmd_col", if1.cmd_col, 0);
    check("rst2.cmp_valid", if1.cmp_valid, 0);
    check("rst2.busy", if1.busy, 0);
    check("rst2.req_ready", if1.req_ready, 1);
    tick(2);
    rst1 = 0;
    tick(150);
    check("rst2.no_pre", q1.size(), n1);
    check("rst2.idle", if1.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
